// File: rtl/cus43_pixel_mixer_if.sv
// Pixel-mixer bus: fetch data, load strobes and CPU writes in; registered pixel out.
// master drives the fetch side and observes the pixel; slave is the mixer.
interface cus43_pixel_mixer_if;
    logic       CLK_2H;
    logic [7:0] GD;
    logic [7:0] RD;
    logic       ATTR_LD_A;
    logic       ATTR_LD_B;
    logic       HA2;
    logic       HB2;
    logic       FLIP;
    logic       nLATCH;
    logic [2:0] CA;
    logic [7:0] CD;
    logic [7:0] COL;
    logic       LAYER;
    logic [2:0] PRI;
    logic       OPAQUE;

    modport master (
        output CLK_2H, GD, RD, ATTR_LD_A, ATTR_LD_B, HA2, HB2, FLIP, nLATCH, CA, CD,
        input  COL, LAYER, PRI, OPAQUE
    );

    modport slave (
        input  CLK_2H, GD, RD, ATTR_LD_A, ATTR_LD_B, HA2, HB2, FLIP, nLATCH, CA, CD,
        output COL, LAYER, PRI, OPAQUE
    );
endinterface

// File: rtl/cus43_pixel_mixer.sv
// Two-layer tile pen serialiser with priority/transparency mix; one registered palette index per clock.
// Load at edge n shows its first pen after edge n+1; no backpressure, the pixel stream is free-running.
module cus43_pixel_mixer #(
    parameter logic [3:0] TRANSPARENT_PEN = 4'hF,
    parameter logic       TIE_LAYER       = 1'b0
) (
    input logic              CLK_6M,
    input logic              rst,
    cus43_pixel_mixer_if.slave bus
);
    // Index 0 is layer A, index 1 is layer B throughout.
    logic [1:0][2:0] pri;
    logic [1:0][7:0] gd_hold;
    logic [1:0][7:0] attr_hold;
    logic [1:0][7:0] shift;
    logic [1:0][7:0] attr;
    logic [1:0]      flip;
    logic [1:0][1:0] cnt;

    logic [1:0]      ld;
    logic [1:0]      attr_ld;
    logic [1:0]      gd_live;
    logic [1:0][3:0] pen;
    logic [1:0]      opaque;
    logic            win;

    logic [7:0] col;
    logic       layer;
    logic [2:0] pri_out;
    logic       opq;

    assign ld      = {bus.HB2, bus.HA2};
    assign attr_ld = {bus.ATTR_LD_B, bus.ATTR_LD_A};
    // GD belongs to layer A while CLK_2H is low and to layer B while it is high.
    assign gd_live = {bus.CLK_2H, ~bus.CLK_2H};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pen[i] = TRANSPARENT_PEN;
            case (cnt[i])
                2'd0:    pen[i] = flip[i] ? shift[i][3:0] : shift[i][7:4];
                2'd1:    pen[i] = flip[i] ? shift[i][7:4] : shift[i][3:0];
                default: pen[i] = TRANSPARENT_PEN;
            endcase
            opaque[i] = (pen[i] != TRANSPARENT_PEN);
        end
    end

    always_comb begin
        win = 1'b0;
        if (opaque[0] && opaque[1]) begin
            if (pri[0] > pri[1])      win = 1'b0;
            else if (pri[1] > pri[0]) win = 1'b1;
            else                      win = TIE_LAYER;
        end else if (opaque[1]) begin
            win = 1'b1;
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            pri       <= '0;
            gd_hold   <= '0;
            attr_hold <= '0;
            shift     <= '0;
            attr      <= '0;
            flip      <= '0;
            cnt       <= {2'd2, 2'd2};
            col       <= '0;
            layer     <= 1'b0;
            pri_out   <= '0;
            opq       <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gd_live[i]) gd_hold[i] <= bus.GD;
                if (attr_ld[i]) attr_hold[i] <= bus.RD;
                if (!bus.nLATCH && bus.CA[1:0] == 2'b01 && bus.CA[2] == i[0])
                    pri[i] <= bus.CD[3:1];
                // Same-edge data bypasses the hold registers so a load never sees stale bytes.
                if (ld[i]) begin
                    shift[i] <= gd_live[i] ? bus.GD : gd_hold[i];
                    attr[i]  <= attr_ld[i] ? bus.RD : attr_hold[i];
                    flip[i]  <= bus.FLIP;
                    cnt[i]   <= 2'd0;
                end else if (cnt[i] != 2'd2) begin
                    cnt[i] <= cnt[i] + 2'd1;
                end
            end
            if (|opaque) begin
                col     <= {attr[win][7:4], pen[win]};
                layer   <= win;
                pri_out <= pri[win];
                opq     <= 1'b1;
            end else begin
                col     <= '0;
                layer   <= 1'b0;
                pri_out <= '0;
                opq     <= 1'b0;
            end
        end
    end

    assign bus.COL    = col;
    assign bus.LAYER  = layer;
    assign bus.PRI    = pri_out;
    assign bus.OPAQUE = opq;
endmodule

// File: tb/tb_cus43_pixel_mixer.sv
// Bench for cus43_pixel_mixer: queue-based pen model feeds a scoreboard; monitor checks every pixel.
module tb_cus43_pixel_mixer;
    localparam logic [3:0] TP  = 4'hF;
    localparam logic       TIE = 1'b0;

    typedef struct packed {
        logic [7:0] col;
        logic       layer;
        logic [2:0] pri;
        logic       opq;
    } exp_t;

    logic CLK_6M = 1'b0;
    logic rst    = 1'b1;
    cus43_pixel_mixer_if bus();

    cus43_pixel_mixer #(.TRANSPARENT_PEN(TP), .TIE_LAYER(TIE)) dut (
        .CLK_6M(CLK_6M),
        .rst   (rst),
        .bus   (bus)
    );

    initial forever #5 CLK_6M = ~CLK_6M;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Model: each layer holds a queue of pending {attr nibble, pen} pixels.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [2:0] m_pri_a, m_pri_b;
    logic [7:0] gh_a, gh_b, ah_a, ah_b;

    always @(negedge CLK_6M) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t g;
            e = exp_q.pop_front();
            g = {bus.COL, bus.LAYER, bus.PRI, bus.OPAQUE};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL pixel t=%0t got col=%h layer=%b pri=%0d opq=%b want col=%h layer=%b pri=%0d opq=%b",
                         $time, g.col, g.layer, g.pri, g.opq, e.col, e.layer, e.pri, e.opq);
            end
        end
    end

    task automatic dchk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    function automatic void load_q(input bit is_b, input logic [7:0] pair, input logic [7:0] at, input logic fl);
        logic [7:0] p0, p1;
        p0 = {at[7:4], fl ? pair[3:0] : pair[7:4]};
        p1 = {at[7:4], fl ? pair[7:4] : pair[3:0]};
        if (is_b) qb = '{p0, p1};
        else      qa = '{p0, p1};
    endfunction

    // Predicts the pixel produced at the coming edge, advances the model, then clocks the DUT.
    task automatic step();
        exp_t e;
        logic [7:0] fa, fb;
        bit oa, ob, w;
        e = '0;
        if (rst) begin
            qa.delete(); qb.delete();
            m_pri_a = 0; m_pri_b = 0;
            gh_a = 0; gh_b = 0; ah_a = 0; ah_b = 0;
        end else begin
            fa = (qa.size() > 0) ? qa.pop_front() : {4'h0, TP};
            fb = (qb.size() > 0) ? qb.pop_front() : {4'h0, TP};
            oa = (fa[3:0] != TP);
            ob = (fb[3:0] != TP);
            if (oa && ob) w = (m_pri_a > m_pri_b) ? 1'b0 : (m_pri_b > m_pri_a) ? 1'b1 : TIE;
            else          w = ob;
            if (oa || ob) e = '{col: w ? fb : fa, layer: w, pri: w ? m_pri_b : m_pri_a, opq: 1'b1};
            if (!bus.nLATCH && bus.CA[1:0] == 2'b01) begin
                if (bus.CA[2]) m_pri_b = bus.CD[3:1];
                else           m_pri_a = bus.CD[3:1];
            end
            if (bus.HA2) load_q(1'b0, !bus.CLK_2H ? bus.GD : gh_a, bus.ATTR_LD_A ? bus.RD : ah_a, bus.FLIP);
            if (bus.HB2) load_q(1'b1,  bus.CLK_2H ? bus.GD : gh_b, bus.ATTR_LD_B ? bus.RD : ah_b, bus.FLIP);
            if (bus.CLK_2H) gh_b = bus.GD;
            else            gh_a = bus.GD;
            if (bus.ATTR_LD_A) ah_a = bus.RD;
            if (bus.ATTR_LD_B) ah_b = bus.RD;
        end
        exp_q.push_back(e);
        @(negedge CLK_6M);
        #1;
    endtask

    task automatic idle();
        bus.CLK_2H = 0; bus.GD = 0; bus.RD = 0;
        bus.ATTR_LD_A = 0; bus.ATTR_LD_B = 0;
        bus.HA2 = 0; bus.HB2 = 0; bus.FLIP = 0;
        bus.nLATCH = 1; bus.CA = 0; bus.CD = 0;
    endtask

    task automatic pri_wr(input logic layer_sel, input logic [7:0] cd);
        idle();
        bus.nLATCH = 0; bus.CA = {layer_sel, 2'b01}; bus.CD = cd;
        step();
    endtask

    task automatic load_both(input logic [7:0] gda, input logic [7:0] ata,
                             input logic [7:0] gdb, input logic [7:0] atb);
        idle();
        bus.CLK_2H = 0; bus.GD = gda; bus.RD = ata; bus.ATTR_LD_A = 1;
        step();
        idle();
        bus.CLK_2H = 1; bus.GD = gdb; bus.RD = atb; bus.ATTR_LD_B = 1;
        bus.HA2 = 1; bus.HB2 = 1;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge CLK_6M);
        #1;
        for (int i = 0; i < 2; i++) begin
            bus.CLK_2H = 1'($urandom); bus.GD = 8'($urandom); bus.RD = 8'($urandom);
            bus.ATTR_LD_A = 1'($urandom); bus.ATTR_LD_B = 1'($urandom);
            bus.HA2 = 1'($urandom); bus.HB2 = 1'($urandom); bus.FLIP = 1'($urandom);
            bus.nLATCH = 1'($urandom); bus.CA = 3'($urandom); bus.CD = 8'($urandom);
            step();
        end
        dchk("reset_col", bus.COL, 8'h00);
        dchk("reset_flags", {4'h0, bus.LAYER, bus.PRI}, 8'h00);
        rst = 0;
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            dchk("post_reset_opaque", {7'h0, bus.OPAQUE}, 8'h00);
        end

        // Single layer, then flipped with FLIP toggling between the two pens.
        for (int f = 0; f < 2; f++) begin
            idle();
            bus.GD = 8'h3A; bus.RD = 8'h50; bus.ATTR_LD_A = 1;
            step();
            idle();
            bus.CLK_2H = 1; bus.GD = 8'hC4; bus.HA2 = 1; bus.FLIP = 1'(f);
            step();
            idle();
            bus.FLIP = 1'(f);
            step();
            dchk("pen1_col", bus.COL, f ? 8'h5A : 8'h53);
            bus.FLIP = ~bus.FLIP;
            step();
            dchk("pen2_col", bus.COL, f ? 8'h53 : 8'h5A);
            step();
            dchk("underrun_opaque", {7'h0, bus.OPAQUE}, 8'h00);
        end

        load_both(8'hF2, 8'h20, 8'h77, 8'h10);
        step();
        dchk("transp_layer", {7'h0, bus.LAYER}, 8'h01);
        dchk("transp_col", bus.COL, 8'h17);
        step();
        dchk("tie_layer0_col", bus.COL, 8'h22);

        pri_wr(1'b0, 8'h0C);
        pri_wr(1'b1, 8'h06);
        load_both(8'h12, 8'h30, 8'h45, 8'h60);
        step();
        dchk("pri_hi_a", {4'h0, bus.LAYER, bus.PRI}, {4'h0, 1'b0, 3'd6});
        dchk("pri_hi_a_col", bus.COL, 8'h31);
        pri_wr(1'b1, 8'h0C);
        load_both(8'h12, 8'h30, 8'h45, 8'h60);
        step();
        dchk("pri_tie", {4'h0, bus.LAYER, bus.PRI}, {4'h0, TIE, 3'd6});
        pri_wr(1'b1, 8'h0E);
        load_both(8'h12, 8'h30, 8'h45, 8'h60);
        step();
        dchk("pri_hi_b", {4'h0, bus.LAYER, bus.PRI}, {4'h0, 1'b1, 3'd7});
        dchk("pri_hi_b_col", bus.COL, 8'h64);
        step();
        step();

        // Back-to-back loads every two clocks.
        for (int k = 0; k < 8; k++) begin
            idle();
            bus.GD = {4'h1, 4'(k)}; bus.HA2 = 1;
            step();
            if (k > 0) dchk("stream_opaque_a", {7'h0, bus.OPAQUE}, 8'h01);
            idle();
            bus.CLK_2H = 1;
            step();
            dchk("stream_opaque_b", {7'h0, bus.OPAQUE}, 8'h01);
        end
        idle();
        rst = 1; bus.GD = 8'h33; bus.HA2 = 1;
        step();
        dchk("midrst_col", bus.COL, 8'h00);
        dchk("midrst_flags", {4'h0, bus.LAYER, bus.PRI}, 8'h00);
        rst = 0;
        idle();
        step();
        dchk("midrst_load_ignored", {7'h0, bus.OPAQUE}, 8'h00);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(63) == 0);
            bus.CLK_2H = ~bus.CLK_2H;
            bus.GD = 8'($urandom); bus.RD = 8'($urandom);
            bus.ATTR_LD_A = 1'($urandom); bus.ATTR_LD_B = 1'($urandom);
            bus.HA2 = ($urandom_range(2) == 0); bus.HB2 = ($urandom_range(2) == 0);
            bus.FLIP = 1'($urandom);
            bus.nLATCH = ($urandom_range(3) != 0);
            bus.CA = 3'($urandom); bus.CD = 8'($urandom);
            step();
        end
        rst = 0;
        idle();
        @(negedge CLK_6M);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cus43_pixel_mixer.md
Name: cus43_pixel_mixer

Overview:
Tilemap pixel stage directly downstream of the tilemap address generator. Per layer it captures tile PROM data (GD) and the tile attribute byte (RD), then serialises 4-bit pens at CLK_6M. Serialisation is aligned by the per-layer fine-scroll load strobes HA2/HB2. It resolves per-pixel priority and transparency between layers A and B and emits one registered palette index per pixel toward the sprite/colour mixer.

Parameters:
TRANSPARENT_PEN, 4'hF, pen value treated as transparent
TIE_LAYER, 0, layer that wins when both layers are opaque with equal priority (0 = A, 1 = B)

Ports:
CLK_6M  in  1  pixel clock; all state updates on rising edge
rst  in  1  reset
CLK_2H  in  1  fetch phase; 0 = GD carries layer A data, 1 = GD carries layer B data
GD  in  8  tile PROM data: two pens, GD[7:4] and GD[3:0]
RD  in  8  tilemap SRAM data (attribute byte)
ATTR_LD_A  in  1  capture RD as pending layer A attribute
ATTR_LD_B  in  1  capture RD as pending layer B attribute
HA2  in  1  layer A pen-pair load strobe
HB2  in  1  layer B pen-pair load strobe
FLIP  in  1  screen flip
nLATCH  in  1  CPU control write strobe, active low
CA  in  3  CPU address; CA[2] selects layer, CA[1:0] selects register
CD  in  8  CPU data
COL  out  8  palette index {attr[7:4], pen[3:0]}
LAYER  out  1  winning layer (0 = A, 1 = B)
PRI  out  3  winning layer priority
OPAQUE  out  1  1 when COL is a visible pixel

Behaviour:
- Clocking: one clock, CLK_6M. rst is synchronous and active-high. rst overrides every other input on the same edge.
- Reset values:
  - COL = 0, LAYER = 0, PRI = 0, OPAQUE = 0.
  - priA = priB = 0; pending GD/attr holds = 0.
  - Pen counters cntA = cntB = 2 (exhausted), so both layers present as transparent.
- Priority register: on an edge with nLATCH = 0 and CA[1:0] = 2'b01, pri[CA[2]] <= CD[3:1]. All other CA[1:0] values are ignored by this block.
- GD capture:
  - Every edge, CLK_2H = 0 → gdA_hold <= GD; CLK_2H = 1 → gdB_hold <= GD.
  - ATTR_LD_x = 1 → attrx_hold <= RD. ATTR_LD_A and ATTR_LD_B may both assert on the same edge; both capture.
- Load (per layer x; A shown):
  - HA2 = 1 at an edge → shiftA <= pen pair, attrA <= attrA_hold, flipA <= FLIP, cntA <= 0.
  - Pen-pair source: if CLK_2H = 0 on the same edge, use GD directly (bypass); otherwise use gdA_hold.
  - The ATTR_LD_A/HA2 same-edge case is decided the same way: the load takes RD directly.
  - FLIP is sampled only at load; a mid-pair FLIP change has no effect until the next load.
- Serialise:
  - With no load, cnt increments and saturates at 2.
  - Pen select:
    - cnt = 0 → first pen: GD[7:4] if flip = 0, else GD[3:0].
    - cnt = 1 → the other pen.
    - cnt = 2 → TRANSPARENT_PEN (underrun).
  - Back-to-back loads every 2 clocks give a continuous pen stream. A load at cnt = 1 truncates the second pen.
- Mix:
  - opaque_x = (pen_x != TRANSPARENT_PEN).
  - Both opaque → winner is the layer with higher pri; equal pri → TIE_LAYER.
  - Exactly one opaque → that layer wins.
  - Neither opaque → COL = 0, LAYER = 0, PRI = 0, OPAQUE = 0.
  - Winner → COL = {attr[7:4], pen}, LAYER, PRI = its pri, OPAQUE = 1.
- Latency:
  - Load at edge n → first pen visible on outputs after edge n+1; second pen after edge n+2.
  - A priority write at edge n affects outputs from edge n+1.
- Fixed widths, no arithmetic overflow paths. pri compare is unsigned 3-bit.

Test Plan:
- Reset: assert rst for 2 clocks with random inputs toggling → COL = 0, OPAQUE = 0, LAYER = 0, PRI = 0. The first 3 edges after release with no HA2/HB2 keep OPAQUE = 0.
- Single layer, no flip: GD = 8'h3A (CLK_2H = 0), RD = 8'h50 with ATTR_LD_A, then HA2 → outputs COL = 8'h53 then 8'h5A on consecutive clocks, then OPAQUE = 0 (underrun).
- Flip: same stimulus with FLIP = 1 at load → COL = 8'h5A then 8'h53. Toggling FLIP between the two pens does not change the order.
- Transparency: layer A GD = 8'hF2, layer B GD = 8'h77 attr 8'h10, equal loads → pixel 1: LAYER = 1, COL = 8'h17. Pixel 2: both opaque, priority decides.
- Priority: nLATCH = 0, CA = 3'b001, CD = 8'h0C → priA = 6; CA = 3'b101, CD = 8'h06 → priB = 3. Both opaque → LAYER = 0, PRI = 6. Then set priB = 6 → LAYER = TIE_LAYER. Then priB = 7 → LAYER = 1.
- Continuous stream and mid-op reset: HA2 every 2 clocks with incrementing GD gives no gaps in OPAQUE. Asserting rst mid-pair → next-edge outputs all zero and cntA = 2. The HA2 coincident with rst is ignored.
